// File: rtl/mem_bank_bl_wl_programmer_if.sv
// Configuration word stream between the bitstream loader (master) and the bank programmer (slave).
interface mem_bank_bl_wl_programmer_if #(
    parameter int DATA_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/mem_bank_bl_wl_programmer.sv
// Programs a bl/wl configuration bank: packs stream words into one bitline row,
// then strobes that row's wordline, walking rows 0..NUM_WL-1.
module mem_bank_bl_wl_programmer #(
    parameter int NUM_BL   = 66,
    parameter int NUM_WL   = 66,
    parameter int DATA_W   = 8,
    parameter int WL_PULSE = 2,
    parameter int ROW_W    = 7
) (
    input  logic                      prog_clk_i,
    input  logic                      prog_reset_i,
    input  logic                      start_i,
    mem_bank_bl_wl_programmer_if.slave cfg,
    output logic [0:NUM_BL-1]         bl_o,
    output logic [0:NUM_WL-1]         wl_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ROW_W-1:0]          row_idx_o
);
    localparam int WPR   = (NUM_BL + DATA_W - 1) / DATA_W;
    localparam int PTR_W = $clog2(WPR * DATA_W + 1);
    localparam int PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
    localparam int BI_W  = (NUM_BL > 1) ? $clog2(NUM_BL) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [0:NUM_BL-1] bl_q, bl_d;
    logic [0:NUM_WL-1] wl_q, wl_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer, last_word, last_row;

    // Bits of the word that land past the end of the row are dropped.
    function automatic logic [0:NUM_BL-1] merge_word(input logic [0:NUM_BL-1] row,
                                                     input logic [PTR_W-1:0]  ptr,
                                                     input logic [DATA_W-1:0] word);
        logic [0:NUM_BL-1] r;
        logic [BI_W-1:0]   k;
        r = row;
        for (int j = 0; j < DATA_W; j++) begin
            if (int'(ptr) + j < NUM_BL) begin
                k    = BI_W'(int'(ptr) + j);
                r[k] = word[j];
            end
        end
        return r;
    endfunction

    // rdy_q is only ever high in LOAD, so a transfer implies LOAD.
    assign xfer      = cfg.cfg_valid & rdy_q;
    assign last_word = (int'(ptr_q) + DATA_W >= NUM_BL);
    assign last_row  = (row_q == ROW_W'(NUM_WL - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        pcnt_d  = pcnt_q;
        bl_d    = bl_q;
        wl_d    = wl_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    ptr_d   = '0;
                    bl_d    = '0;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    bl_d  = merge_word(bl_q, ptr_q, cfg.cfg_data);
                    ptr_d = ptr_q + PTR_W'(DATA_W);
                    if (last_word) begin
                        state_d = S_SETUP;
                        rdy_d   = 1'b0;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                pcnt_d  = '0;
                for (int k = 0; k < NUM_WL; k++) begin
                    wl_d[k] = (row_q == ROW_W'(k));
                end
            end
            S_PULSE: begin
                if (pcnt_q == PC_W'(WL_PULSE - 1)) begin
                    state_d = S_HOLD;
                    wl_d    = '0;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
            S_HOLD: begin
                bl_d = '0;
                if (last_row) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_LOAD;
                    row_d   = row_q + ROW_W'(1);
                    ptr_d   = '0;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wl_d    = '0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    // Async reset so wl drops mid-pulse without waiting for a prog_clk edge.
    always_ff @(posedge prog_clk_i or posedge prog_reset_i) begin
        if (prog_reset_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            ptr_q   <= '0;
            pcnt_q  <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ptr_q   <= ptr_d;
            pcnt_q  <= pcnt_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cfg.cfg_ready = rdy_q;
    assign bl_o          = bl_q;
    assign wl_o          = wl_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign row_idx_o     = row_q;
endmodule

// File: tb/tb_mem_bank_bl_wl_programmer.sv
// Bench for the bl/wl bank programmer: randomized streams against a row-image model of the bank.
`timescale 1ns/1ps
module tb_mem_bank_bl_wl_programmer;
    localparam int DW    = 8;
    localparam int NBL_A = 66, NWL_A = 66, WLP_A = 2;
    localparam int NBL_B = 16, NWL_B = 4,  WLP_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit         sel;
    logic       st, vld;
    logic [7:0] dat;
    int         n_cmp = 0, n_err = 0;

    logic                 start_a, start_b;
    logic [0:NBL_A-1]     bl_a;
    logic [0:NWL_A-1]     wl_a;
    logic                 busy_a, done_a;
    logic [6:0]           row_a;
    logic [0:NBL_B-1]     bl_b;
    logic [0:NWL_B-1]     wl_b;
    logic                 busy_b, done_b;
    logic [2:0]           row_b;

    mem_bank_bl_wl_programmer_if #(.DATA_W(DW)) if_a ();
    mem_bank_bl_wl_programmer_if #(.DATA_W(DW)) if_b ();

    assign start_a        = st & ~sel;
    assign start_b        = st & sel;
    assign if_a.cfg_valid = vld & ~sel;
    assign if_b.cfg_valid = vld & sel;
    assign if_a.cfg_data  = dat;
    assign if_b.cfg_data  = dat;

    mem_bank_bl_wl_programmer #(.NUM_BL(NBL_A), .NUM_WL(NWL_A), .DATA_W(DW), .WL_PULSE(WLP_A), .ROW_W(7)) dut_a (
        .prog_clk_i(clk), .prog_reset_i(rst), .start_i(start_a), .cfg(if_a),
        .bl_o(bl_a), .wl_o(wl_a), .busy_o(busy_a), .done_o(done_a), .row_idx_o(row_a));

    mem_bank_bl_wl_programmer #(.NUM_BL(NBL_B), .NUM_WL(NWL_B), .DATA_W(DW), .WL_PULSE(WLP_B), .ROW_W(3)) dut_b (
        .prog_clk_i(clk), .prog_reset_i(rst), .start_i(start_b), .cfg(if_b),
        .bl_o(bl_b), .wl_o(wl_b), .busy_o(busy_b), .done_o(done_b), .row_idx_o(row_b));

    // View of whichever DUT is selected, bit k of bl/wl at index k.
    logic [127:0] m_bl, m_wl;
    logic         m_rdy, m_busy, m_done;
    logic [7:0]   m_row;
    always_comb begin
        m_bl = '0; m_wl = '0; m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_row = '0;
        if (sel) begin
            for (int k = 0; k < NBL_B; k++) m_bl[k] = bl_b[k];
            for (int k = 0; k < NWL_B; k++) m_wl[k] = wl_b[k];
            m_rdy = if_b.cfg_ready; m_busy = busy_b; m_done = done_b; m_row = 8'(row_b);
        end else begin
            for (int k = 0; k < NBL_A; k++) m_bl[k] = bl_a[k];
            for (int k = 0; k < NWL_A; k++) m_wl[k] = wl_a[k];
            m_rdy = if_a.cfg_ready; m_busy = busy_a; m_done = done_a; m_row = 8'(row_a);
        end
    end

    function automatic int nbl(); return sel ? NBL_B : NBL_A; endfunction
    function automatic int nwl(); return sel ? NWL_B : NWL_A; endfunction
    function automatic int wlp(); return sel ? WLP_B : WLP_A; endfunction
    function automatic int wpr(); return (nbl() + DW - 1) / DW; endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse recorder: every wl pulse becomes (row, bl seen at rising edge, length).
    typedef struct {int row; logic [127:0] bl; int len;} pulse_t;
    pulse_t       pq[$];
    int           cur_row, cur_len;
    logic [127:0] cur_bl, prev_wl = '0;
    logic         prev_rdy = 1'b0;
    int           v_hot = 0, v_blchg = 0, v_rdy = 0;

    always @(negedge clk) begin
        if (m_wl != '0) begin
            if (!$onehot(m_wl)) v_hot++;
            if (m_rdy) v_rdy++;
            if (prev_wl == '0) begin
                if (prev_rdy) v_rdy++;
                cur_row = -1;
                for (int k = 127; k >= 0; k--) if (m_wl[k]) cur_row = k;
                cur_bl  = m_bl;
                cur_len = 1;
            end else begin
                cur_len++;
                if (m_wl != prev_wl) v_hot++;
                if (m_bl != cur_bl) v_blchg++;
            end
        end else if (prev_wl != '0) begin
            if (m_rdy) v_rdy++;
            pq.push_back('{cur_row, cur_bl, cur_len});
        end
        if (m_done && m_rdy) v_rdy++;
        prev_wl  = m_wl;
        prev_rdy = m_rdy;
    end

    logic [7:0]   words   [0:1023];
    logic [127:0] exp_row [0:127];

    // mode 0: random words, mode 1: all-ones on even rows, zeros on odd rows.
    task automatic build(input int mode);
        for (int r = 0; r < nwl(); r++) begin
            for (int w = 0; w < wpr(); w++)
                words[r*wpr()+w] = (mode == 1) ? ((r % 2 == 0) ? 8'hFF : 8'h00) : 8'($urandom);
            exp_row[r] = '0;
            for (int k = 0; k < nbl(); k++) begin
                logic [7:0] wv;
                wv = words[r*wpr() + k/DW];
                exp_row[r][k] = wv[k % DW];
            end
        end
    endtask

    task automatic clear_mon();
        #1;
        pq.delete();
        v_hot = 0; v_blchg = 0; v_rdy = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); st = 1'b1;
        @(negedge clk); st = 1'b0;
    endtask

    task automatic stream(input int first, input int last, input int duty);
        int idx; bit rl; int cyc;
        idx = first; rl = 1'b0; cyc = 0; vld = 1'b0;
        while (idx < last && cyc < 20000) begin
            @(negedge clk); cyc++;
            if (vld && rl) idx++;
            if (idx < last) begin
                vld = ($urandom_range(99) < duty);
                dat = words[idx];
            end else vld = 1'b0;
            rl = m_rdy;
        end
        vld = 1'b0;
        if (idx < last) chk("stream_timeout", 128'(idx), 128'(last));
    endtask

    task automatic wait_done(input string tn);
        int c; c = 0;
        while (!m_done && c < 2000) begin @(negedge clk); c++; end
        #1;
        if (!m_done) chk({tn, "_done_timeout"}, 128'(m_done), 128'(1));
    endtask

    task automatic check_bank(input string tn);
        chk({tn, "_npulse"}, 128'(pq.size()), 128'(nwl()));
        for (int i = 0; i < pq.size() && i < nwl(); i++) begin
            chk($sformatf("%s_row%0d_idx", tn, i), 128'(pq[i].row), 128'(i));
            chk($sformatf("%s_row%0d_len", tn, i), 128'(pq[i].len), 128'(wlp()));
            chk($sformatf("%s_row%0d_bl", tn, i), pq[i].bl, exp_row[i]);
        end
        chk({tn, "_multihot"}, 128'(v_hot), 128'(0));
        chk({tn, "_bl_chg_in_pulse"}, 128'(v_blchg), 128'(0));
        chk({tn, "_ready_outside_load"}, 128'(v_rdy), 128'(0));
        chk({tn, "_done"}, 128'(m_done), 128'(1));
        chk({tn, "_busy_done"}, 128'(m_busy), 128'(0));
        chk({tn, "_bl_done"}, m_bl, 128'(0));
        chk({tn, "_wl_done"}, m_wl, 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; st = 1'b0; vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        sel = 1'b0; st = 1'b0; vld = 1'b0; dat = '0; rst = 1'b1;
        #2;
        chk("rst_bl", m_bl, 128'(0));
        chk("rst_wl", m_wl, 128'(0));
        chk("rst_busy", 128'(m_busy), 128'(0));
        chk("rst_done", 128'(m_done), 128'(0));
        chk("rst_ready", 128'(m_rdy), 128'(0));
        chk("rst_row", 128'(m_row), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1: random data, valid held high
        build(0); clear_mon(); pulse_start();
        chk("T1_busy_after_start", 128'(m_busy), 128'(1));
        stream(0, nwl()*wpr(), 100); wait_done("T1"); check_bank("T1");

        // T2: stripe pattern, also restart straight from DONE
        build(1); clear_mon(); pulse_start();
        chk("T2_restart_done", 128'(m_done), 128'(0));
        chk("T2_restart_row", 128'(m_row), 128'(0));
        chk("T2_restart_busy", 128'(m_busy), 128'(1));
        stream(0, nwl()*wpr(), 100); wait_done("T2"); check_bank("T2");

        // T3: 30% valid duty
        build(0); clear_mon(); pulse_start();
        stream(0, nwl()*wpr(), 30); wait_done("T3"); check_bank("T3");

        // T5: start during LOAD of row 3 is ignored
        build(0); clear_mon(); pulse_start();
        stream(0, 3*wpr(), 100);
        for (int c = 0; c < 50 && m_row != 8'd3; c++) @(negedge clk);
        chk("T5_reach_row3", 128'(m_row), 128'(3));
        pulse_start();
        chk("T5_row_after_start", 128'(m_row), 128'(3));
        chk("T5_busy_after_start", 128'(m_busy), 128'(1));
        stream(3*wpr(), nwl()*wpr(), 100); wait_done("T5"); check_bank("T5");

        // T4: async reset in the middle of row 5's pulse
        build(0); clear_mon(); pulse_start();
        stream(0, 6*wpr(), 100);
        for (int c = 0; c < 50 && !m_wl[5]; c++) @(negedge clk);
        chk("T4_reach_pulse5", 128'(m_wl[5]), 128'(1));
        #1 rst = 1'b1;
        #1;
        chk("T4_rst_wl", m_wl, 128'(0));
        chk("T4_rst_bl", m_bl, 128'(0));
        chk("T4_rst_busy", 128'(m_busy), 128'(0));
        chk("T4_rst_ready", 128'(m_rdy), 128'(0));
        chk("T4_rst_row", 128'(m_row), 128'(0));
        @(negedge clk); rst = 1'b0;
        clear_mon(); pulse_start();
        stream(0, nwl()*wpr(), 100); wait_done("T4"); check_bank("T4");

        // T6: small bank, single-cycle pulses
        sel = 1'b1;
        do_reset();
        build(0); clear_mon(); pulse_start();
        stream(0, nwl()*wpr(), 100); wait_done("T6"); check_bank("T6");
        build(0); clear_mon(); pulse_start();
        stream(0, nwl()*wpr(), 30); wait_done("T6b"); check_bank("T6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
